// File: rtl/lms_sample_feeder_if.sv
// rtl/lms_sample_feeder_if.sv - host byte stream and sample output bundle for lms_sample_feeder
interface lms_sample_feeder_if #(
  parameter int AW = 4
);
  logic          enable_i;
  logic          sync_i;
  logic [7:0]    byte_i;
  logic          byte_valid_i;
  logic          byte_ready_o;
  logic [15:0]   data_in_o;
  logic [15:0]   data_ref_o;
  logic          sample_stb_o;
  logic          underflow_o;
  logic [AW:0]   level_o;

  // Host side: drives bytes and control, observes samples.
  modport master (
    output enable_i, sync_i, byte_i, byte_valid_i,
    input  byte_ready_o, data_in_o, data_ref_o, sample_stb_o, underflow_o, level_o
  );

  // Feeder side.
  modport slave (
    input  enable_i, sync_i, byte_i, byte_valid_i,
    output byte_ready_o, data_in_o, data_ref_o, sample_stb_o, underflow_o, level_o
  );
endinterface

// File: rtl/lms_sample_feeder.sv
// rtl/lms_sample_feeder.sv - byte-to-frame assembler, frame FIFO and ticked sample presenter
module lms_sample_feeder #(
  parameter int DIV   = 40,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lms_sample_feeder_if.slave bus
);
  localparam int            CW       = $clog2(DIV);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    pos_q;
  logic [23:0]   stage_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   in_q;
  logic [15:0]   ref_q;
  logic          stb_q;
  logic          uf_q;

  logic          ready;
  logic          accept;
  logic [1:0]    slot;
  logic          frame_wr;
  logic          tick;
  logic          pop;

  // Ready looks only at the registered level so a same-edge pop never opens it early.
  assign ready    = (level_q != FULL);
  assign accept   = bus.byte_valid_i && ready;
  // A resync coinciding with a byte makes that byte the first of a new frame.
  assign slot     = bus.sync_i ? 2'd0 : pos_q;
  assign frame_wr = accept && (slot == 2'd3);
  assign tick     = bus.enable_i && (cnt_q == CNT_LAST);
  assign pop      = tick && (level_q != '0);

  assign bus.byte_ready_o = ready;
  assign bus.data_in_o    = in_q;
  assign bus.data_ref_o   = ref_q;
  assign bus.sample_stb_o = stb_q;
  assign bus.underflow_o  = uf_q;
  assign bus.level_o      = level_q;

  // Byte position tracking and staging of the first three bytes of a frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q   <= 2'd0;
      stage_q <= '0;
    end else if (accept) begin
      case (slot)
        2'd0:    stage_q[7:0]   <= bus.byte_i;
        2'd1:    stage_q[15:8]  <= bus.byte_i;
        2'd2:    stage_q[23:16] <= bus.byte_i;
        default: ;
      endcase
      pos_q <= slot + 2'd1;
    end else if (bus.sync_i) begin
      pos_q <= 2'd0;
    end
  end

  // Frame storage: the fourth byte completes {ref, in} and lands directly in the FIFO.
  always_ff @(posedge clk_i) begin
    if (frame_wr) begin
      mem[wr_ptr_q] <= {bus.byte_i, stage_q};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (frame_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({frame_wr, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: ;
      endcase
    end
  end

  // Sample tick divider; held at zero while disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || !bus.enable_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Output pair, strobe and sticky underflow, all updated on the tick edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_q  <= '0;
      ref_q <= '0;
      stb_q <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      stb_q <= pop;
      if (pop) begin
        {ref_q, in_q} <= mem[rd_ptr_q];
      end
      if (tick && (level_q == '0)) begin
        uf_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lms_sample_feeder.sv
// tb/tb_lms_sample_feeder.sv - self-checking bench for lms_sample_feeder
module tb_lms_sample_feeder;
  localparam int DIV   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  lms_sample_feeder_if #(.AW(AW)) bus ();

  lms_sample_feeder #(.DIV(DIV), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model state
  logic [31:0] fq[$];
  logic [7:0]  staged[$];
  int          m_run;
  int          m_pops;
  logic [15:0] m_in, m_ref;
  logic        m_stb, m_uf;
  bit          m_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: frames are whole 4-byte groups; a tick is every DIV-th consecutive enabled edge.
  initial begin
    int sz;
    logic [31:0] f;
    forever begin
      @(posedge clk_i);
      if (rst_i) begin
        fq.delete(); staged.delete();
        m_run = 0; m_pops = 0; m_in = 0; m_ref = 0; m_stb = 0; m_uf = 0;
        m_valid = 1'b1;
      end else begin
        sz = fq.size();
        m_stb = 0;
        if (bus.enable_i) m_run++; else m_run = 0;
        if (bus.enable_i && (m_run % DIV == 0)) begin
          if (sz > 0) begin
            f = fq.pop_front();
            m_in = f[15:0]; m_ref = f[31:16]; m_stb = 1; m_pops++;
          end else begin
            m_uf = 1;
          end
        end
        if (bus.sync_i) staged.delete();
        if (bus.byte_valid_i && sz != DEPTH) begin
          staged.push_back(bus.byte_i);
          if (staged.size() == 4) begin
            fq.push_back({staged[3], staged[2], staged[1], staged[0]});
            staged.delete();
          end
        end
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  initial begin
    forever begin
      @(negedge clk_i);
      if (m_valid && !rst_i) begin
        chk("level",     32'(bus.level_o),      32'(fq.size()));
        chk("ready",     32'(bus.byte_ready_o), 32'(fq.size() != DEPTH));
        chk("data_in",   32'(bus.data_in_o),    32'(m_in));
        chk("data_ref",  32'(bus.data_ref_o),   32'(m_ref));
        chk("stb",       32'(bus.sample_stb_o), 32'(m_stb));
        chk("underflow", 32'(bus.underflow_o),  32'(m_uf));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    cyc(n);
    rst_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    bit done = 0;
    bus.byte_i = b;
    bus.byte_valid_i = 1'b1;
    for (int t = 0; t < 200; t++) begin
      ok = bus.byte_ready_o;
      @(negedge clk_i);
      if (ok) begin done = 1; break; end
    end
    bus.byte_valid_i = 1'b0;
    chk("byte_accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_frame(input logic [15:0] din, input logic [15:0] dref);
    send_byte(din[7:0]);
    send_byte(din[15:8]);
    send_byte(dref[7:0]);
    send_byte(dref[15:8]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r;
    bus.enable_i = 1'b1; bus.sync_i = 1'b0; bus.byte_i = 8'h00; bus.byte_valid_i = 1'b0;
    cyc(1);

    // Reset and idle: underflow appears after the first tick (4th edge)
    do_reset(2);
    chk("rst_in",    32'(bus.data_in_o), 32'h0);
    chk("rst_ref",   32'(bus.data_ref_o), 32'h0);
    chk("rst_ready", 32'(bus.byte_ready_o), 32'h1);
    chk("rst_level", 32'(bus.level_o), 32'h0);
    cyc(3);
    chk("uf_before_tick", 32'(bus.underflow_o), 32'h0);
    cyc(1);
    chk("uf_after_tick", 32'(bus.underflow_o), 32'h1);
    cyc(4);
    chk("uf_sticky", 32'(bus.underflow_o), 32'h1);

    // Single frame
    bus.enable_i = 1'b0;
    do_reset(1);
    send_frame(16'h1234, 16'hABCD);
    chk("single_level", 32'(bus.level_o), 32'h1);
    bus.enable_i = 1'b1;
    cyc(3);
    chk("single_nostb", 32'(bus.sample_stb_o), 32'h0);
    cyc(1);
    chk("single_in",  32'(bus.data_in_o), 32'h1234);
    chk("single_ref", 32'(bus.data_ref_o), 32'hABCD);
    chk("single_stb", 32'(bus.sample_stb_o), 32'h1);
    chk("model_in",   32'(m_in), 32'h1234);
    cyc(1);
    chk("single_stb_drop", 32'(bus.sample_stb_o), 32'h0);
    chk("single_hold", 32'(bus.data_in_o), 32'h1234);
    bus.enable_i = 1'b0;

    // Fill to full, one tick frees a slot, pending byte accepted afterwards
    do_reset(1);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    chk("full_level", 32'(bus.level_o), 32'd16);
    chk("full_ready", 32'(bus.byte_ready_o), 32'h0);
    chk("model_full", 32'(fq.size()), 32'd16);
    bus.byte_i = 8'h77; bus.byte_valid_i = 1'b1;
    cyc(3);
    chk("full_blocked", 32'(bus.level_o), 32'd16);
    bus.enable_i = 1'b1;
    cyc(4);
    bus.enable_i = 1'b0;
    chk("full_pop_level", 32'(bus.level_o), 32'd15);
    chk("full_pop_ready", 32'(bus.byte_ready_o), 32'h1);
    chk("full_pop_in",    32'(bus.data_in_o), 32'h0100);
    chk("full_pop_ref",   32'(bus.data_ref_o), 32'h0302);
    cyc(1);
    bus.byte_valid_i = 1'b0;
    send_byte(8'h88); send_byte(8'h99); send_byte(8'hAA);
    chk("full_refill", 32'(bus.level_o), 32'd16);

    // Resync drops staged bytes; sync with a byte makes it position 0
    do_reset(1);
    send_byte(8'h11); send_byte(8'h22);
    bus.sync_i = 1'b1; cyc(1); bus.sync_i = 1'b0;
    send_frame(16'h0001, 16'hFFFF);
    send_byte(8'hAA); send_byte(8'hBB);
    bus.sync_i = 1'b1; send_byte(8'h02); bus.sync_i = 1'b0;
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    chk("sync_level", 32'(bus.level_o), 32'd2);
    bus.enable_i = 1'b1;
    cyc(4);
    chk("sync_in",  32'(bus.data_in_o), 32'h0001);
    chk("sync_ref", 32'(bus.data_ref_o), 32'hFFFF);
    cyc(4);
    chk("sync2_in",  32'(bus.data_in_o), 32'h0002);
    chk("sync2_ref", 32'(bus.data_ref_o), 32'h0003);
    bus.enable_i = 1'b0;

    // Streaming in order, producer keeps the FIFO non-empty
    do_reset(1);
    send_frame(16'd1, -16'sd1);
    send_frame(16'd2, -16'sd2);
    bus.enable_i = 1'b1;
    for (int k = 3; k <= 20; k++) begin
      r = -16'(k);
      send_frame(16'(k), r);
    end
    for (int t = 0; t < 400 && m_pops < 20; t++) cyc(1);
    bus.enable_i = 1'b0;
    chk("stream_pops", 32'(m_pops), 32'd20);
    chk("stream_last_in",  32'(bus.data_in_o), 32'h0014);
    chk("stream_last_ref", 32'(bus.data_ref_o), 32'hFFEC);
    chk("stream_no_uf",    32'(bus.underflow_o), 32'h0);

    // Reset mid-frame discards the partial frame
    do_reset(1);
    send_byte(8'h99); send_byte(8'h98);
    do_reset(1);
    send_frame(16'h0005, 16'h0006);
    chk("midrst_level", 32'(bus.level_o), 32'h1);
    bus.enable_i = 1'b1;
    cyc(4);
    bus.enable_i = 1'b0;
    chk("midrst_in",  32'(bus.data_in_o), 32'h0005);
    chk("midrst_ref", 32'(bus.data_ref_o), 32'h0006);
    chk("midrst_stb", 32'(bus.sample_stb_o), 32'h1);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
